// File: rtl/pong_pkg.sv
// Shared widths, reset positions, FSM state type and the frame record
// used by the frame-synchronous display update path.
package pong_pkg;

  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int BCD_W       = 4;
  localparam int SCORE_W     = 2 * BCD_W;
  localparam int FRAME_CNT_W = 8;

  localparam int BALL_X_RST   = 316;
  localparam int BALL_Y_RST   = 236;
  localparam int PADDLE_Y_RST = 200;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [X_W-1:0]     ball_x;
    logic [Y_W-1:0]     ball_y;
    logic [Y_W-1:0]     paddle_l_y;
    logic [Y_W-1:0]     paddle_r_y;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
  } frame_state_t;

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] digit);
    return (digit > BCD_W'(9)) ? BCD_W'(9) : digit;
  endfunction

endpackage

// File: rtl/bcd_clamp.sv
// Two-digit BCD sanitiser: each nibble above 9 is forced to 9 so the score
// renderer never sees an undefined glyph index.
module bcd_clamp
  import pong_pkg::*;
(
  input  logic [SCORE_W-1:0] bcd_in,
  output logic [SCORE_W-1:0] bcd_out
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      assign bcd_out[gi*BCD_W +: BCD_W] = clamp_digit(bcd_in[gi*BCD_W +: BCD_W]);
    end
  endgenerate

endmodule

// File: rtl/frame_update_scheduler.sv
// Double-buffers game-state updates: a producer stages one update into a
// shadow bank, which is published to the display only at a frame boundary.
module frame_update_scheduler
  import pong_pkg::*;
#(
  parameter int FRAME_DIV = 2,
  parameter int BALL_X0   = BALL_X_RST,
  parameter int BALL_Y0   = BALL_Y_RST,
  parameter int PADDLE_Y0 = PADDLE_Y_RST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               screen_end,
  input  logic               freeze,
  input  logic               upd_req,
  input  logic [X_W-1:0]     upd_ball_x,
  input  logic [Y_W-1:0]     upd_ball_y,
  input  logic [Y_W-1:0]     upd_paddle_l_y,
  input  logic [Y_W-1:0]     upd_paddle_r_y,
  input  logic [SCORE_W-1:0] upd_score_l,
  input  logic [SCORE_W-1:0] upd_score_r,
  input  logic               clr_late,
  output logic               upd_ack,
  output logic               tick,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic [Y_W-1:0]     paddle_l_y,
  output logic [Y_W-1:0]     paddle_r_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               late
);

  localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_DIV - 1);

  localparam frame_state_t RESET_FRAME = '{
    ball_x:     X_W'(BALL_X0),
    ball_y:     Y_W'(BALL_Y0),
    paddle_l_y: Y_W'(PADDLE_Y0),
    paddle_r_y: Y_W'(PADDLE_Y0),
    score_l:    '0,
    score_r:    '0
  };

  sched_state_t           state_reg, state_next;
  frame_state_t           shadow_reg, display_reg;
  frame_state_t           staged_in, commit_frame;
  logic                   capture, commit;
  logic                   ack_reg, tick_reg;
  logic                   late_reg, late_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   frame_adv, frame_wrap;
  logic                   tick_seen_reg, commit_seen_reg;
  logic [SCORE_W-1:0]     score_l_clamped, score_r_clamped;

  assign staged_in = '{
    ball_x:     upd_ball_x,
    ball_y:     upd_ball_y,
    paddle_l_y: upd_paddle_l_y,
    paddle_r_y: upd_paddle_r_y,
    score_l:    upd_score_l,
    score_r:    upd_score_r
  };

  bcd_clamp u_clamp_l (
    .bcd_in  (shadow_reg.score_l),
    .bcd_out (score_l_clamped)
  );

  bcd_clamp u_clamp_r (
    .bcd_in  (shadow_reg.score_r),
    .bcd_out (score_r_clamped)
  );

  always_comb begin
    commit_frame         = shadow_reg;
    commit_frame.score_l = score_l_clamped;
    commit_frame.score_r = score_r_clamped;
  end

  // A full shadow bank back-pressures the producer until the next unfrozen frame end.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (upd_req) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (screen_end && !freeze) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shadow_reg  <= '0;
      display_reg <= RESET_FRAME;
      ack_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= capture;
      if (capture) shadow_reg <= staged_in;
      if (commit) display_reg <= commit_frame;
    end
  end

  assign frame_adv  = screen_end && !freeze;
  assign frame_wrap = frame_adv && (frame_cnt_reg == FRAME_LAST);

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    if (frame_wrap) begin
      frame_cnt_next = '0;
    end else if (frame_adv) begin
      frame_cnt_next = frame_cnt_reg + 1'b1;
    end
  end

  // A commit landing on the tick edge itself still counts toward that tick.
  always_comb begin
    late_next = late_reg;
    if (frame_wrap && tick_seen_reg && !(commit_seen_reg || commit)) begin
      late_next = 1'b1;
    end else if (clr_late) begin
      late_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg   <= '0;
      tick_reg        <= 1'b0;
      late_reg        <= 1'b0;
      tick_seen_reg   <= 1'b0;
      commit_seen_reg <= 1'b0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      tick_reg      <= frame_wrap;
      late_reg      <= late_next;
      if (frame_wrap) begin
        tick_seen_reg   <= 1'b1;
        commit_seen_reg <= 1'b0;
      end else if (commit) begin
        commit_seen_reg <= 1'b1;
      end
    end
  end

  assign upd_ack    = ack_reg;
  assign tick       = tick_reg;
  assign late       = late_reg;
  assign ball_x     = display_reg.ball_x;
  assign ball_y     = display_reg.ball_y;
  assign paddle_l_y = display_reg.paddle_l_y;
  assign paddle_r_y = display_reg.paddle_r_y;
  assign score_l    = display_reg.score_l;
  assign score_r    = display_reg.score_r;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench: a transaction-level model predicts acks, ticks, display
// commits and late-flag changes; a monitor pops and compares on DUT activity.
module tb_frame_update_scheduler;

  localparam int FRAME_DIV = 2;
  localparam int BX0 = 316;
  localparam int BY0 = 236;
  localparam int PY0 = 200;

  typedef logic [52:0] disp_t;
  typedef struct {
    int          cyc;
    logic [63:0] val;
  } ev_t;

  localparam disp_t RST_DISP = {10'(BX0), 9'(BY0), 9'(PY0), 9'(PY0), 8'h00, 8'h00};

  logic       clk = 1'b0;
  logic       reset;
  logic       screen_end = 1'b0, freeze = 1'b0, upd_req = 1'b0, clr_late = 1'b0;
  logic [9:0] upd_ball_x = '0;
  logic [8:0] upd_ball_y = '0, upd_paddle_l_y = '0, upd_paddle_r_y = '0;
  logic [7:0] upd_score_l = '0, upd_score_r = '0;
  logic       upd_ack, tick, late;
  logic [9:0] ball_x;
  logic [8:0] ball_y, paddle_l_y, paddle_r_y;
  logic [7:0] score_l, score_r;

  always #5 clk = ~clk;

  frame_update_scheduler #(.FRAME_DIV(FRAME_DIV)) dut (
    .clk(clk), .reset(reset), .screen_end(screen_end), .freeze(freeze),
    .upd_req(upd_req), .upd_ball_x(upd_ball_x), .upd_ball_y(upd_ball_y),
    .upd_paddle_l_y(upd_paddle_l_y), .upd_paddle_r_y(upd_paddle_r_y),
    .upd_score_l(upd_score_l), .upd_score_r(upd_score_r), .clr_late(clr_late),
    .upd_ack(upd_ack), .tick(tick), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .score_l(score_l), .score_r(score_r), .late(late)
  );

  int  cyc = 0;
  int  n_vec = 0;
  int  n_miss = 0;
  int  tick_count = 0;
  ev_t q_ack[$], q_tick[$], q_disp[$], q_late[$];

  // Reference model state: what the game-state pipeline should be doing.
  bit         pend_m, have_req, commit_since_m, late_m;
  int         frames_m, ticks_m;
  disp_t      stage_m, disp_m, req_m;
  logic [9:0] last_x;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_ev(string name, int act_cyc, int exp_cyc);
    n_vec++;
    n_miss++;
    $display("FAIL %s: seen at cycle %0d, expected at cycle %0d", name, act_cyc, exp_cyc);
  endfunction

  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    int t, o;
    t = int'(v) / 16;
    o = int'(v) % 16;
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return 8'(t * 16 + o);
  endfunction

  function automatic ev_t mk(input int c, input logic [63:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  task automatic model_reset();
    pend_m = 0; have_req = 0; commit_since_m = 0; late_m = 0;
    frames_m = 0; ticks_m = 0;
    disp_m = RST_DISP; stage_m = '0; last_x = 10'(BX0);
  endtask

  // Predict the effect of the coming clock edge given the inputs just driven.
  task automatic model_edge(input bit req, input bit se, input bit frz, input bit clr);
    int e;
    bit accept, commit_now, set_late, old_late;
    e          = cyc + 1;
    accept     = req && !pend_m;
    commit_now = pend_m && se && !frz;
    old_late   = late_m;
    set_late   = 0;
    if (commit_now) begin
      disp_m = {stage_m[52:16], clamp_bcd(stage_m[15:8]), clamp_bcd(stage_m[7:0])};
      pend_m = 0;
      commit_since_m = 1;
      q_disp.push_back(mk(e, 64'(disp_m)));
    end
    if (accept) begin
      stage_m  = req_m;
      last_x   = req_m[52:43];
      pend_m   = 1;
      have_req = 0;
      q_ack.push_back(mk(e, 0));
    end
    if (se && !frz) begin
      frames_m++;
      if (frames_m % FRAME_DIV == 0) begin
        q_tick.push_back(mk(e, 0));
        set_late = (ticks_m > 0) && !commit_since_m;
        ticks_m++;
        commit_since_m = 0;
      end
    end
    if (set_late) late_m = 1;
    else if (clr) late_m = 0;
    if (late_m != old_late) q_late.push_back(mk(e, 64'(late_m)));
  endtask

  task automatic cycle(input bit se, input bit frz, input bit clr);
    @(negedge clk);
    screen_end = se;
    freeze     = frz;
    clr_late   = clr;
    upd_req    = have_req;
    {upd_ball_x, upd_ball_y, upd_paddle_l_y, upd_paddle_r_y, upd_score_l, upd_score_r} = req_m;
    model_edge(have_req, se, frz, clr);
  endtask

  task automatic post(input logic [9:0] x, input logic [8:0] y, input logic [8:0] pl,
                      input logic [8:0] pr, input logic [7:0] sl, input logic [7:0] sr);
    req_m    = {x, y, pl, pr, sl, sr};
    have_req = 1;
  endtask

  task automatic post_random();
    logic [9:0] x;
    do x = 10'($urandom_range(0, 1023)); while (x == last_x);
    post(x, 9'($urandom), 9'($urandom), 9'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    screen_end = 0; freeze = 0; clr_late = 0; upd_req = 0;
    if (disp_m != RST_DISP) q_disp.push_back(mk(cyc + 1, 64'(RST_DISP)));
    if (late_m) q_late.push_back(mk(cyc + 1, 0));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // Monitor: overdue expectations first, then whatever the DUT presents now.
  disp_t prev_disp = RST_DISP;
  logic  prev_late = 1'b0;

  always @(posedge clk) begin : monitor
    ev_t   ev;
    disp_t cur;
    #1;
    while (q_ack.size() > 0 && q_ack[0].cyc < cyc) begin
      ev = q_ack.pop_front(); fail_ev("ack_missing", -1, ev.cyc);
    end
    while (q_tick.size() > 0 && q_tick[0].cyc < cyc) begin
      ev = q_tick.pop_front(); fail_ev("tick_missing", -1, ev.cyc);
    end
    while (q_disp.size() > 0 && q_disp[0].cyc < cyc) begin
      ev = q_disp.pop_front(); fail_ev("commit_missing", -1, ev.cyc);
    end
    while (q_late.size() > 0 && q_late[0].cyc < cyc) begin
      ev = q_late.pop_front(); fail_ev("late_change_missing", -1, ev.cyc);
    end
    if (upd_ack === 1'b1) begin
      $display("ack    cyc=%0d", cyc);
      if (q_ack.size() == 0) fail_ev("ack_unexpected", cyc, -1);
      else begin ev = q_ack.pop_front(); chk("ack_cycle", 64'(cyc), 64'(ev.cyc)); end
    end
    if (tick === 1'b1) begin
      tick_count++;
      $display("tick   cyc=%0d late=%0b", cyc, late);
      if (q_tick.size() == 0) fail_ev("tick_unexpected", cyc, -1);
      else begin ev = q_tick.pop_front(); chk("tick_cycle", 64'(cyc), 64'(ev.cyc)); end
    end
    cur = {ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r};
    if (cur !== prev_disp) begin
      $display("commit cyc=%0d x=%0d y=%0d pl=%0d pr=%0d sl=%h sr=%h",
               cyc, ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r);
      if (q_disp.size() == 0) fail_ev("display_change_unexpected", cyc, -1);
      else begin
        ev = q_disp.pop_front();
        chk("display_cycle", 64'(cyc), 64'(ev.cyc));
        chk("display_value", 64'(cur), ev.val);
      end
      prev_disp = cur;
    end
    if (late !== prev_late) begin
      $display("late   cyc=%0d value=%0b", cyc, late);
      if (q_late.size() == 0) fail_ev("late_change_unexpected", cyc, -1);
      else begin
        ev = q_late.pop_front();
        chk("late_cycle", 64'(cyc), 64'(ev.cyc));
        chk("late_value", 64'(late), ev.val);
      end
      prev_late = late;
    end
  end

  initial begin : stimulus
    int t0;
    bit se, se_prev, frz;
    reset = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ball_x", 64'(ball_x), 64'(BX0));
    chk("rst_ball_y", 64'(ball_y), 64'(BY0));
    chk("rst_paddle_l", 64'(paddle_l_y), 64'(PY0));
    chk("rst_paddle_r", 64'(paddle_r_y), 64'(PY0));
    chk("rst_score_l", 64'(score_l), 0);
    chk("rst_score_r", 64'(score_r), 0);
    chk("rst_ack", 64'(upd_ack), 0);
    chk("rst_tick", 64'(tick), 0);
    chk("rst_late", 64'(late), 0);
    reset = 1;

    // Single update: acked next cycle, displayed only after screen_end.
    post(100, 236, 200, 200, 8'h00, 8'h00);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("s1_hold_x", 64'(ball_x), 316);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s1_commit_x", 64'(ball_x), 100);

    // Back-to-back requests: second waits for the first commit.
    do_reset();
    post(100, 236, 200, 200, 8'h00, 8'h00);
    cycle(0, 0, 0);
    post(200, 236, 200, 200, 8'h00, 8'h00);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s2_first_x", 64'(ball_x), 100);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s2_second_x", 64'(ball_x), 200);

    // Request and screen_end together in IDLE: no bypass.
    do_reset();
    post(317, 50, 200, 200, 8'h00, 8'h00);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s3_hold_y", 64'(ball_y), 236);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s3_commit_y", 64'(ball_y), 50);

    // Tick division, then freeze during pulses 3-4 with a pending update.
    do_reset();
    t0 = tick_count;
    for (int k = 1; k <= 6; k++) begin
      cycle(1, 0, 0);
      cycle(0, 0, 0);
    end
    chk("s4_ticks_free", 64'(tick_count - t0), 3);
    t0 = tick_count;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) post(400, 100, 100, 100, 8'h12, 8'h34);
      cycle(1, (k == 3 || k == 4), 0);
      cycle(0, 0, 0);
      if (k == 4) chk("s4_frozen_x", 64'(ball_x), 316);
    end
    chk("s4_ticks_frozen", 64'(tick_count - t0), 2);
    chk("s4_commit_x", 64'(ball_x), 400);

    // BCD clamp and late flag.
    do_reset();
    post(10, 100, 100, 100, 8'hA7, 8'h3C);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0);
      cycle(0, 0, 0);
    end
    chk("s5_score_l", 64'(score_l), 64'h97);
    chk("s5_score_r", 64'(score_r), 64'h39);
    chk("s5_late_set", 64'(late), 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("s5_late_clr", 64'(late), 0);

    // Reset while an update is pending discards it.
    post(5, 100, 10, 100, 8'h00, 8'h00);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    do_reset();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("s6_paddle_l", 64'(paddle_l_y), 200);
    chk("s6_ball_x", 64'(ball_x), 316);

    // Randomised traffic with busy and sparse producer phases.
    se_prev = 0;
    frz = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 800 == 799) do_reset();
      if (!have_req) begin
        if (((i / 500) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0))
          post_random();
      end
      if ($urandom_range(0, 39) == 0) frz = !frz;
      se = !se_prev && ($urandom_range(0, 3) == 0);
      cycle(se, frz, $urandom_range(0, 15) == 0);
      se_prev = se;
    end

    have_req = 0;
    repeat (8) cycle(0, 0, 0);
    chk("left_ack", 64'(q_ack.size()), 0);
    chk("left_tick", 64'(q_tick.size()), 0);
    chk("left_commit", 64'(q_disp.size()), 0);
    chk("left_late", 64'(q_late.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
